// File: rtl/multi_pattern_sequencer_if.sv
// ROM read port shared by every sequencer channel.
// Protocol: the master drives rom_addr every cycle (0 when nobody is granted) and the
// slave returns the word for that address on rom_data one cycle later. There is no
// valid/ready pair: the ROM never stalls, and a channel only consumes rom_data in the
// cycle after its own grant.
interface multi_pattern_sequencer_if #(
   parameter int ROM_AW = 8
);
   logic [ROM_AW-1:0] rom_addr;
   logic [15:0]       rom_data;

   modport master (output rom_addr, input rom_data);
   modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/multi_pattern_sequencer.sv
// NUM_CH pattern sequencers (header -> order list -> notes) sharing one synchronous song
// ROM through a round-robin arbiter. Define PATSEQ_STATUS_EN to add sticky o_stb_overrun.
module multi_pattern_sequencer #(
   parameter int          NUM_CH   = 4,
   parameter int          ROM_AW   = 8,
   parameter int unsigned PAT_BASE = 0
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic [NUM_CH-1:0]     i_note_stb,
   output logic [NUM_CH-1:0]     o_note_valid,
   output logic [6*NUM_CH-1:0]   o_note_pitch,
   output logic [5*NUM_CH-1:0]   o_note_len,
   output logic [4*NUM_CH-1:0]   o_note_instrument,
   output logic [NUM_CH-1:0]     o_ch_stopped,
`ifdef PATSEQ_STATUS_EN
   output logic [NUM_CH-1:0]     o_stb_overrun,
`endif
   multi_pattern_sequencer_if.master rom_bus
);

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

   typedef enum logic [3:0] {
      S_INIT, S_HDR_REQ, S_HDR_RD, S_ORD_REQ, S_ORD_RD,
      S_PAT_REQ, S_PAT_RD, S_NOTE, S_IDLE, S_IDLE_PAT, S_STOPPED
   } state_e;

   logic [NUM_CH-1:0] req;
   logic [ROM_AW-1:0] req_addr [NUM_CH];
   logic              gnt_valid;
   int                gnt_ch;
   logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
   logic [ROM_AW-1:0] rom_addr_c;

   // Lowest requester overall, then overridden by the lowest at or above the pointer.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_ch    = 0;
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (req[c]) begin
            gnt_valid = 1'b1;
            gnt_ch    = c;
         end
      end
      for (int c = NUM_CH - 1; c >= 0; c--) begin
         if (req[c] && (c >= int'(rr_ptr_q))) gnt_ch = c;
      end
   end

   always_comb begin
      rr_ptr_d = rr_ptr_q;
      if (gnt_valid) rr_ptr_d = (gnt_ch >= NUM_CH - 1) ? '0 : PTR_W'(gnt_ch + 1);
   end

   always_comb begin
      rom_addr_c = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (gnt_valid && (gnt_ch == c)) rom_addr_c = req_addr[c];
      end
   end

   assign rom_bus.rom_addr = rom_addr_c;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) rr_ptr_q <= '0;
      else          rr_ptr_q <= rr_ptr_d;
   end

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      state_e            state_q, state_d;
      logic [5:0]        last_q, last_d, rep_addr_q, rep_addr_d, ord_idx_q, ord_idx_d;
      logic              rep_q, rep_d, pend_q, pend_d;
      logic [ROM_AW-1:0] pat_addr_q, pat_addr_d;
      logic [7:0]        pat_len_q, pat_len_d, count_q, count_d;
      logic [5:0]        pitch_q, pitch_d;
      logic [4:0]        len_q, len_d;
      logic [3:0]        inst_q, inst_d;
      logic              granted, stb;
`ifdef PATSEQ_STATUS_EN
      logic              ovr_q, ovr_d;
`endif

      assign granted = gnt_valid && (gnt_ch == g);
      assign stb     = i_note_stb[g];
      assign req[g]  = (state_q == S_HDR_REQ) || (state_q == S_ORD_REQ) || (state_q == S_PAT_REQ);
      assign req_addr[g] = (state_q == S_HDR_REQ) ? ROM_AW'(g) :
                           (state_q == S_ORD_REQ) ? {{(ROM_AW-6){1'b0}}, ord_idx_q} :
                                                    pat_addr_q;

      always_comb begin
         state_d    = state_q;
         last_d     = last_q;
         rep_addr_d = rep_addr_q;
         rep_d      = rep_q;
         ord_idx_d  = ord_idx_q;
         pat_addr_d = pat_addr_q;
         pat_len_d  = pat_len_q;
         count_d    = count_q;
         pitch_d    = pitch_q;
         len_d      = len_q;
         inst_d     = inst_q;
         pend_d     = pend_q;
`ifdef PATSEQ_STATUS_EN
         ovr_d      = ovr_q;
`endif
         // Strobes arriving mid-fetch are remembered once; a second one is lost.
         if (stb && !(state_q inside {S_INIT, S_IDLE, S_IDLE_PAT, S_STOPPED})) begin
            if (!pend_q) pend_d = 1'b1;
`ifdef PATSEQ_STATUS_EN
            else         ovr_d  = 1'b1;
`endif
         end
         case (state_q)
            S_INIT:    if (stb) state_d = S_HDR_REQ;
            S_HDR_REQ: if (granted) state_d = S_HDR_RD;
            S_HDR_RD: begin
               last_d     = rom_bus.rom_data[5:0];
               rep_addr_d = rom_bus.rom_data[11:6];
               rep_d      = rom_bus.rom_data[12];
               ord_idx_d  = 6'd1;
               state_d    = S_ORD_REQ;
            end
            S_ORD_REQ: if (granted) state_d = S_ORD_RD;
            S_ORD_RD: begin
               pat_addr_d = ROM_AW'(rom_bus.rom_data[7:0]) + ROM_AW'(PAT_BASE);
               pat_len_d  = rom_bus.rom_data[15:8];
               count_d    = 8'd1;
               state_d    = S_PAT_REQ;
            end
            S_PAT_REQ: if (granted) state_d = S_PAT_RD;
            S_PAT_RD: begin
               pitch_d = rom_bus.rom_data[5:0];
               len_d   = rom_bus.rom_data[10:6];
               inst_d  = rom_bus.rom_data[14:11];
               state_d = S_NOTE;
            end
            S_NOTE: begin
               // count starts at 1, so pat_len 0 ends the pattern after one note.
               if (count_q < pat_len_q) begin
                  pat_addr_d = pat_addr_q + ROM_AW'(1);
                  count_d    = count_q + 8'd1;
                  state_d    = S_IDLE_PAT;
               end else if (ord_idx_q != last_q) begin
                  ord_idx_d = ord_idx_q + 6'd1;
                  state_d   = S_IDLE;
               end else if (rep_q) begin
                  ord_idx_d = rep_addr_q;
                  state_d   = S_IDLE;
               end else begin
                  state_d = S_STOPPED;
               end
            end
            S_IDLE: if (stb || pend_q) begin
               pend_d  = 1'b0;
               state_d = S_ORD_REQ;
            end
            S_IDLE_PAT: if (stb || pend_q) begin
               pend_d  = 1'b0;
               state_d = S_PAT_REQ;
            end
            S_STOPPED: state_d = S_STOPPED;
            default:   state_d = S_INIT;
         endcase
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            state_q    <= S_INIT;
            last_q     <= '0;
            rep_addr_q <= '0;
            rep_q      <= 1'b0;
            ord_idx_q  <= '0;
            pat_addr_q <= '0;
            pat_len_q  <= '0;
            count_q    <= '0;
            pitch_q    <= '0;
            len_q      <= '0;
            inst_q     <= '0;
            pend_q     <= 1'b0;
`ifdef PATSEQ_STATUS_EN
            ovr_q      <= 1'b0;
`endif
         end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            rep_addr_q <= rep_addr_d;
            rep_q      <= rep_d;
            ord_idx_q  <= ord_idx_d;
            pat_addr_q <= pat_addr_d;
            pat_len_q  <= pat_len_d;
            count_q    <= count_d;
            pitch_q    <= pitch_d;
            len_q      <= len_d;
            inst_q     <= inst_d;
            pend_q     <= pend_d;
`ifdef PATSEQ_STATUS_EN
            ovr_q      <= ovr_d;
`endif
         end
      end

      assign o_note_valid[g]          = (state_q == S_NOTE);
      assign o_ch_stopped[g]          = (state_q == S_STOPPED);
      assign o_note_pitch[6*g +: 6]   = pitch_q;
      assign o_note_len[5*g +: 5]     = len_q;
      assign o_note_instrument[4*g +: 4] = inst_q;
`ifdef PATSEQ_STATUS_EN
      assign o_stb_overrun[g]         = ovr_q;
`endif
   end

endmodule

// File: tb/tb_multi_pattern_sequencer.sv
// Directed bench for multi_pattern_sequencer: a 4-channel instance plus a 1-channel
// instance with PAT_BASE=0x80, each backed by its own synchronous ROM model.
module tb_multi_pattern_sequencer;

   localparam logic [15:0] NOTE_A = 16'h10C5;  // pitch 5,  len 3,  inst 2
   localparam logic [15:0] NOTE_B = 16'h7FFF;  // pitch 63, len 31, inst 15
   localparam logic [15:0] NOTE_C = 16'h1909;  // pitch 9,  len 4,  inst 3
   localparam logic [15:0] NOTE_D = 16'h556A;  // pitch 42, len 21, inst 10
   localparam logic [15:0] NOTE_P1 = 16'h0841; // pitch 1,  len 1,  inst 1
   localparam logic [15:0] NOTE_P2 = 16'h1082; // pitch 2,  len 2,  inst 2

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- DUT A: 4 channels ----------------
   logic [3:0]  stb;
   logic [3:0]  note_valid;
   logic [23:0] note_pitch;
   logic [19:0] note_len;
   logic [15:0] note_inst;
   logic [3:0]  ch_stopped;
`ifdef PATSEQ_STATUS_EN
   logic [3:0]  stb_ovr;
`endif
   logic [15:0] rom_mem [256];
   multi_pattern_sequencer_if #(.ROM_AW(8)) rom_if ();

   multi_pattern_sequencer #(.NUM_CH(4), .ROM_AW(8), .PAT_BASE(0)) dut (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_note_stb        (stb),
      .o_note_valid      (note_valid),
      .o_note_pitch      (note_pitch),
      .o_note_len        (note_len),
      .o_note_instrument (note_inst),
      .o_ch_stopped      (ch_stopped),
`ifdef PATSEQ_STATUS_EN
      .o_stb_overrun     (stb_ovr),
`endif
      .rom_bus           (rom_if)
   );

   always @(posedge clk) rom_if.rom_data <= rom_mem[rom_if.rom_addr];

   // ---------------- DUT B: 1 channel, PAT_BASE = 0x80 ----------------
   logic        stb_b;
   logic        note_valid_b;
   logic [5:0]  note_pitch_b;
   logic [4:0]  note_len_b;
   logic [3:0]  note_inst_b;
   logic        ch_stopped_b;
`ifdef PATSEQ_STATUS_EN
   logic        stb_ovr_b;
`endif
   logic [15:0] rom_b_mem [256];
   multi_pattern_sequencer_if #(.ROM_AW(8)) rom_if_b ();

   multi_pattern_sequencer #(.NUM_CH(1), .ROM_AW(8), .PAT_BASE(8'h80)) dut_b (
      .i_clk             (clk),
      .i_rst_n           (rst_n),
      .i_note_stb        (stb_b),
      .o_note_valid      (note_valid_b),
      .o_note_pitch      (note_pitch_b),
      .o_note_len        (note_len_b),
      .o_note_instrument (note_inst_b),
      .o_ch_stopped      (ch_stopped_b),
`ifdef PATSEQ_STATUS_EN
      .o_stb_overrun     (stb_ovr_b),
`endif
      .rom_bus           (rom_if_b)
   );

   always @(posedge clk) rom_if_b.rom_data <= rom_b_mem[rom_if_b.rom_addr];

   // ---------------- scoreboard ----------------
   logic [17:0] exp_q [$];
   logic [17:0] obs_q [$];
   int          obs_cyc_q [$];
   logic [17:0] obs_b_q [$];
   int          obs_b_cyc_q [$];
   int          checks = 0;
   int          failures = 0;

   // Expected observation word: {channel, pitch, len, instrument} of a ROM note word.
   function automatic logic [17:0] nw(input int ch, input logic [15:0] w);
      return {3'(ch), w[5:0], w[10:6], w[14:11]};
   endfunction

   always @(negedge clk) begin
      for (int c = 0; c < 4; c++) begin
         if (note_valid[c]) begin
            obs_q.push_back({3'(c), note_pitch[6*c +: 6], note_len[5*c +: 5], note_inst[4*c +: 4]});
            obs_cyc_q.push_back(cyc);
         end
      end
      if (note_valid_b) begin
         obs_b_q.push_back({3'd0, note_pitch_b, note_len_b, note_inst_b});
         obs_b_cyc_q.push_back(cyc);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic strobe(input logic [3:0] m, output int n);
      n = cyc;
      stb = m;
      step(1);
      stb = '0;
   endtask

   task automatic rom_init();
      for (int i = 0; i < 256; i++) begin
         rom_mem[i]   = 16'h6000 + 16'(i);
         rom_b_mem[i] = 16'h6000 + 16'(i);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      stb   = '0;
      stb_b = 1'b0;
      step(2);
      rst_n = 1'b1;
      step(1);
      obs_q.delete();
      obs_cyc_q.delete();
      obs_b_q.delete();
      obs_b_cyc_q.delete();
      exp_q.delete();
   endtask

   task automatic compare_notes(input string name);
      checks++;
      if (obs_q.size() != exp_q.size()) begin
         failures++;
         $display("FAIL %s_count: got %0d notes, want %0d", name, obs_q.size(), exp_q.size());
      end else begin
         for (int i = 0; i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin
               failures++;
               $display("FAIL %s_note[%0d]: got %h want %h", name, i, obs_q[i], exp_q[i]);
            end
         end
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      stb   = '0;
      stb_b = 1'b0;
      step(2);
      checks++;
      if (note_valid !== 4'h0 || ch_stopped !== 4'h0) begin
         failures++;
         $display("FAIL reset_valid: got valid=%h stopped=%h want 0/0", note_valid, ch_stopped);
      end
      checks++;
      if ({note_pitch, note_len, note_inst} !== 60'h0) begin
         failures++;
         $display("FAIL reset_fields: got %h want 0", {note_pitch, note_len, note_inst});
      end
      checks++;
      if (rom_if.rom_addr !== 8'h00 || rom_if_b.rom_addr !== 8'h00) begin
         failures++;
         $display("FAIL reset_rom_addr: got %h/%h want 00/00", rom_if.rom_addr, rom_if_b.rom_addr);
      end
      checks++;
      if ({note_valid_b, note_pitch_b, note_len_b, note_inst_b, ch_stopped_b} !== 17'h0) begin
         failures++;
         $display("FAIL reset_dut_b: got %h want 0",
                  {note_valid_b, note_pitch_b, note_len_b, note_inst_b, ch_stopped_b});
      end
`ifdef PATSEQ_STATUS_EN
      checks++;
      if (stb_ovr !== 4'h0 || stb_ovr_b !== 1'b0) begin
         failures++;
         $display("FAIL reset_overrun: got %h/%b want 0/0", stb_ovr, stb_ovr_b);
      end
`endif
      rst_n = 1'b1;
      step(3);
      checks++;
      if (rom_if.rom_addr !== 8'h00 || note_valid !== 4'h0) begin
         failures++;
         $display("FAIL reset_quiet: got addr=%h valid=%h want 00/0", rom_if.rom_addr, note_valid);
      end
   endtask

   task automatic test_single_song();
      int n1, n2, n3;
      rom_init();
      rom_mem[0] = 16'h0001;
      rom_mem[1] = 16'h0210;
      rom_mem[8'h10] = NOTE_A;
      rom_mem[8'h11] = NOTE_B;
      do_reset();
      strobe(4'b0001, n1); step(10);
      strobe(4'b0001, n2); step(10);
      strobe(4'b0001, n3); step(10);
      exp_q.push_back(nw(0, NOTE_A));
      exp_q.push_back(nw(0, NOTE_B));
      compare_notes("single");
      if (obs_cyc_q.size() == 2) begin
         checks++;
         if (obs_cyc_q[0] - n1 != 7) begin
            failures++;
            $display("FAIL single_init_latency: got %0d want 7", obs_cyc_q[0] - n1);
         end
         checks++;
         if (obs_cyc_q[1] - n2 != 3) begin
            failures++;
            $display("FAIL single_pat_latency: got %0d want 3", obs_cyc_q[1] - n2);
         end
         checks++;
         if (obs_cyc_q[1] >= n3) begin
            failures++;
            $display("FAIL single_after_stop: note at %0d, stop strobe at %0d", obs_cyc_q[1], n3);
         end
      end
      checks++;
      if (ch_stopped !== 4'b0001) begin
         failures++;
         $display("FAIL single_stopped: got %b want 0001", ch_stopped);
      end
   endtask

   task automatic test_repeat();
      int n [5];
      rom_init();
      rom_mem[0] = 16'h1042;  // last=2, repeat_addr=1, repeat=1
      rom_mem[1] = 16'h0120;
      rom_mem[2] = 16'h0130;
      rom_mem[8'h20] = NOTE_P1;
      rom_mem[8'h30] = NOTE_P2;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         strobe(4'b0001, n[i]);
         step(10);
      end
      exp_q.push_back(nw(0, NOTE_P1));
      exp_q.push_back(nw(0, NOTE_P2));
      exp_q.push_back(nw(0, NOTE_P1));
      exp_q.push_back(nw(0, NOTE_P2));
      exp_q.push_back(nw(0, NOTE_P1));
      compare_notes("repeat");
      if (obs_cyc_q.size() >= 2) begin
         checks++;
         if (obs_cyc_q[1] - n[1] != 5) begin
            failures++;
            $display("FAIL repeat_idle_latency: got %0d want 5", obs_cyc_q[1] - n[1]);
         end
      end
      checks++;
      if (ch_stopped !== 4'b0000) begin
         failures++;
         $display("FAIL repeat_stopped: got %b want 0000", ch_stopped);
      end
   endtask

   task automatic test_contention();
      int n;
      rom_init();
      rom_mem[1] = 16'h0110;
      rom_mem[8'h10] = NOTE_A;
      do_reset();
      strobe(4'b1111, n);
      step(25);
      for (int c = 0; c < 4; c++) exp_q.push_back(nw(c, NOTE_A));
      compare_notes("contend");
      if (obs_cyc_q.size() == 4) begin
         for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs_cyc_q[c] - n != 11 + c) begin
               failures++;
               $display("FAIL contend_cycle[%0d]: got %0d want %0d", c, obs_cyc_q[c] - n, 11 + c);
            end
         end
      end
   endtask

   task automatic test_pending();
      int n, m, k;
      rom_init();
      rom_mem[0] = 16'h0003;
      rom_mem[1] = 16'h0110;
      rom_mem[2] = 16'h0111;
      rom_mem[3] = 16'h0112;
      rom_mem[8'h10] = NOTE_A;
      rom_mem[8'h11] = NOTE_B;
      rom_mem[8'h12] = NOTE_C;
      // One strobe during ORD_RD is held and replayed without a further strobe.
      do_reset();
      strobe(4'b0001, n);
      step(3);
      strobe(4'b0001, m);
      step(20);
      exp_q.push_back(nw(0, NOTE_A));
      exp_q.push_back(nw(0, NOTE_B));
      compare_notes("pend");
      if (obs_cyc_q.size() == 2) begin
         checks++;
         if (obs_cyc_q[0] - n != 7 || obs_cyc_q[1] - m != 9) begin
            failures++;
            $display("FAIL pend_cycles: got %0d,%0d want 7,9", obs_cyc_q[0] - n, obs_cyc_q[1] - m);
         end
      end
`ifdef PATSEQ_STATUS_EN
      checks++;
      if (stb_ovr !== 4'b0000) begin
         failures++;
         $display("FAIL pend_no_overrun: got %b want 0000", stb_ovr);
      end
`endif
      // Two strobes during the fetch: the second is dropped.
      do_reset();
      strobe(4'b0001, n);
      step(1);
      strobe(4'b0001, m);
      step(1);
      strobe(4'b0001, k);
      step(25);
      exp_q.push_back(nw(0, NOTE_A));
      exp_q.push_back(nw(0, NOTE_B));
      compare_notes("drop");
      checks++;
      if (ch_stopped !== 4'b0000) begin
         failures++;
         $display("FAIL drop_stopped: got %b want 0000", ch_stopped);
      end
`ifdef PATSEQ_STATUS_EN
      checks++;
      if (stb_ovr !== 4'b0001) begin
         failures++;
         $display("FAIL drop_overrun: got %b want 0001", stb_ovr);
      end
`endif
   endtask

   task automatic test_boundaries();
      int n1, n2, n3;
      rom_init();
      rom_mem[0] = 16'h0002;
      rom_mem[1] = 16'h0010;  // pat_len 0
      rom_mem[2] = 16'h0112;
      rom_mem[8'h10] = NOTE_A;
      rom_mem[8'h11] = NOTE_B;
      rom_mem[8'h12] = NOTE_C;
      rom_b_mem[0] = 16'h0001;
      rom_b_mem[1] = 16'h0190;  // 0x90 + 0x80 wraps to 0x10
      rom_b_mem[8'h10] = NOTE_A;
      rom_b_mem[8'h90] = NOTE_D;
      do_reset();
      strobe(4'b0001, n1); step(10);
      strobe(4'b0001, n2); step(10);
      strobe(4'b0001, n3); step(10);
      exp_q.push_back(nw(0, NOTE_A));
      exp_q.push_back(nw(0, NOTE_C));
      compare_notes("len0");
      if (obs_cyc_q.size() == 2) begin
         checks++;
         if (obs_cyc_q[1] - n2 != 5) begin
            failures++;
            $display("FAIL len0_next_order_latency: got %0d want 5", obs_cyc_q[1] - n2);
         end
      end
      checks++;
      if (ch_stopped !== 4'b0001) begin
         failures++;
         $display("FAIL len0_stopped: got %b want 0001 (strobe3 at %0d)", ch_stopped, n3);
      end
      n1 = cyc;
      stb_b = 1'b1;
      step(1);
      stb_b = 1'b0;
      step(4);
      checks++;
      if (rom_if_b.rom_addr !== 8'h10) begin
         failures++;
         $display("FAIL wrap_addr: got %h want 10", rom_if_b.rom_addr);
      end
      step(10);
      checks++;
      if (obs_b_q.size() != 1) begin
         failures++;
         $display("FAIL wrap_count: got %0d want 1", obs_b_q.size());
      end else begin
         checks++;
         if (obs_b_q[0] !== nw(0, NOTE_A) || obs_b_cyc_q[0] - n1 != 7) begin
            failures++;
            $display("FAIL wrap_note: got %h at +%0d want %h at +7",
                     obs_b_q[0], obs_b_cyc_q[0] - n1, nw(0, NOTE_A));
         end
      end
   endtask

   task automatic test_reset_mid_fetch();
      int n;
      rom_init();
      rom_mem[1] = 16'h0210;
      rom_mem[2] = 16'h0001;
      rom_mem[8'h10] = NOTE_A;
      rom_mem[8'h11] = NOTE_B;
      do_reset();
      strobe(4'b0100, n);
      step(10);
      strobe(4'b0100, n);
      checks++;
      if (rom_if.rom_addr !== 8'h11 || note_pitch[17:12] !== 6'd5) begin
         failures++;
         $display("FAIL midreset_pre: got addr=%h pitch=%0d want 11/5", rom_if.rom_addr, note_pitch[17:12]);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (rom_if.rom_addr !== 8'h00 || note_valid !== 4'h0 || ch_stopped !== 4'h0 ||
          {note_pitch, note_len, note_inst} !== 60'h0) begin
         failures++;
         $display("FAIL midreset_outputs: got addr=%h valid=%h fields=%h want all 0",
                  rom_if.rom_addr, note_valid, {note_pitch, note_len, note_inst});
      end
      step(1);
      rst_n = 1'b1;
      step(1);
      obs_q.delete();
      obs_cyc_q.delete();
      strobe(4'b0100, n);
      checks++;
      if (rom_if.rom_addr !== 8'h02) begin
         failures++;
         $display("FAIL midreset_hdr_addr: got %h want 02", rom_if.rom_addr);
      end
      step(10);
      exp_q.push_back(nw(2, NOTE_A));
      compare_notes("midreset");
      if (obs_cyc_q.size() == 1) begin
         checks++;
         if (obs_cyc_q[0] - n != 7) begin
            failures++;
            $display("FAIL midreset_latency: got %0d want 7", obs_cyc_q[0] - n);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      stb   = '0;
      stb_b = 1'b0;
      rom_init();
      test_reset();
      test_single_song();
      test_repeat();
      test_contention();
      test_pending();
      test_boundaries();
      test_reset_mid_fetch();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded 200000 time units");
      $fatal(1, "timeout");
   end

endmodule
